tx_beam_ch: RTL
===============

Name: tx_beam_ch

Overview:
- Per-channel transmit-focusing pulse generator; the transmit counterpart of the receive DBF channel.
- On a fire strobe it looks up the channel's transmit focusing delay for the selected scan line, waits that many clocks, then drives a bipolar burst (tx_p/tx_n) to the channel pulser.
- One instance per element; all instances share fire, line_sel and burst settings, and each has its own delay LUT.

Parameters:
- ADDR_WD, 7: width of the delay-LUT address (scan-line index); LUT depth is 2^ADDR_WD.
- DLY_WD, 12: transmit delay width, in clock cycles.
- HALF_WD, 6: half-period width, in clocks.
- CYC_WD, 4: burst cycle-count width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_en  in  1  transmit window enable; low aborts any activity.
- fire  in  1  single-cycle transmit trigger.
- line_sel  in  ADDR_WD  scan line whose delay is used on fire.
- lut_addr  in  ADDR_WD  delay-LUT write address.
- lut_we  in  1  delay-LUT write enable.
- lut_din  in  DLY_WD  delay-LUT write data (unsigned clocks).
- half_per  in  HALF_WD  clocks per burst half-period.
- n_cycles  in  CYC_WD  number of full burst cycles.
- tx_p  out  1  positive pulser drive.
- tx_n  out  1  negative pulser drive.
- tx_busy  out  1  high while a transmit is in progress.
- tx_done  out  1  one-cycle strobe when a burst completes.

Behaviour:
- Reset: tx_p, tx_n, tx_busy and tx_done are 0; FSM goes to IDLE; all counters are 0. LUT contents are not reset.
- LUT write:
  - Synchronous; on lut_we, lut_din is written to lut_addr.
  - Reads are read-before-write: a same-cycle write to the address being read returns the old data.
  - Writes are allowed at any time; the delay already latched for an in-flight transmit is unaffected.
- FSM states: IDLE, LOAD, DELAY, PULSE, DONE.
- IDLE:
  - fire=1 with tx_en=1 at cycle T: capture line_sel into the LUT read, and sample half_per and n_cycles. Go to LOAD.
  - fire in any other state, or with tx_en=0, is ignored.
- LOAD (T+1): LUT data D is loaded into the delay counter. Go to DELAY, or directly to PULSE if D=0.
- DELAY: count down D clocks.
- PULSE timing:
  - The first tx_p high cycle is T+2+D.
  - tx_p is high for H clocks, then tx_n is high for H clocks; this repeats n_cycles times.
  - H = half_per, with half_per=0 treated as H=1.
  - Total burst length is 2*H*n_cycles clocks.
  - If n_cycles=0, PULSE is skipped: no output pulse, go straight to DONE.
- DONE: tx_done=1 for exactly one cycle, outputs low; next state IDLE.
- tx_busy: 1 in LOAD, DELAY, PULSE and DONE.
- tx_p and tx_n are registered outputs and are never simultaneously 1.
- Abort: tx_en low in any non-IDLE state:
  - On the next edge all outputs go to 0 and the FSM returns to IDLE.
  - No tx_done is issued.
  - A fire in the same cycle as the abort is ignored.
- Back-to-back: fire is accepted in the cycle after DONE (IDLE); the minimum fire-to-fire spacing is 2*H*n_cycles+D+3 clocks.
- Counter widths: DLY_WD for the delay, HALF_WD for the half-period, CYC_WD+1 for the half-period count. No wrap-around can occur.

Optional Feature:
- Macro: TX_DEADTIME_EN.
- Defined:
  - The first clock of every half-period except the very first tx_p half is driven with both outputs low (dead time at each polarity change).
  - Total burst length and the first-edge timing are unchanged. Each affected half is high for H-1 clocks; when H=1 those halves are fully low.
- Undefined: polarity switches directly with no dead time.

Decomposition:
- Shared package (tx_pkg): FSM state encoding, and default widths ADDR_WD, DLY_WD, HALF_WD, CYC_WD, also used by the transmit sequencer and the LUT loader.
- One sub-module: tx_dly_lut. Single-port-write / single-port-read synchronous RAM, ADDR_WD x DLY_WD, read-before-write, inferred as BRAM/distributed RAM.

Test Plan:
- Delay 5, half_per=3, n_cycles=2:
  - Stimulus: write LUT[4]=5, fire with line_sel=4, half_per=3, n_cycles=2 at T.
  - Response: tx_p high T+7..T+9, tx_n T+10..T+12, tx_p T+13..T+15, tx_n T+16..T+18, tx_done at T+19, tx_busy T+1..T+19.
- Zero delay / zero cycles:
  - LUT[0]=0, half_per=1, n_cycles=1: tx_p at T+2, tx_n at T+3, tx_done at T+4.
  - n_cycles=0: tx_done at T+2+D with no pulse.
- Abort: fire with D=10, deassert tx_en at T+15 (mid-burst). Outputs 0 and tx_busy 0 at T+16; no tx_done; a later fire restarts cleanly.
- Busy and write collision:
  - A second fire while tx_busy=1 is ignored; burst timing is unchanged.
  - Writing LUT[4]=20 in the same cycle as fire on line 4 (old value 5) uses 5; the next fire uses 20.
- Reset mid-PULSE: assert rst_n=0 asynchronously. All outputs are 0 immediately (no clock edge needed); FSM is IDLE after release.
- TX_DEADTIME_EN, half_per=3, n_cycles=2:
  - Both outputs low at T+10, T+13 and T+16.
  - tx_p high T+7..T+9 and T+14..T+15; tx_n high T+11..T+12 and T+17..T+18.
  - tx_done still at T+19.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the transmit beamforming path: default widths and
// the transmit sequencer state encoding.
package tx_pkg;

    localparam int ADDR_WD = 7;
    localparam int DLY_WD  = 12;
    localparam int HALF_WD = 6;
    localparam int CYC_WD  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DELAY,
        ST_PULSE,
        ST_DONE
    } tx_state_t;

endpackage

// File: rtl/tx_dly_lut.sv
// Per-channel transmit focusing delay table, one entry per scan line.
// Synchronous read-before-write RAM suitable for BRAM/distributed RAM.
module tx_dly_lut #(
    parameter int ADDR_WD = tx_pkg::ADDR_WD,
    parameter int DLY_WD  = tx_pkg::DLY_WD
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_WD-1:0] waddr,
    input  logic [DLY_WD-1:0]  wdata,
    input  logic               re,
    input  logic [ADDR_WD-1:0] raddr,
    output logic [DLY_WD-1:0]  rdata
);

    logic [DLY_WD-1:0] mem [0:(1<<ADDR_WD)-1];

    // Read and write share the edge, so a colliding read sees the old entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tx_beam_ch.sv
// Per-element transmit focusing pulse generator: delays a fire strobe by the
// channel's LUT delay, then emits a bipolar burst. Optional: TX_DEADTIME_EN.
module tx_beam_ch #(
    parameter int ADDR_WD = tx_pkg::ADDR_WD,
    parameter int DLY_WD  = tx_pkg::DLY_WD,
    parameter int HALF_WD = tx_pkg::HALF_WD,
    parameter int CYC_WD  = tx_pkg::CYC_WD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_en,
    input  logic               fire,
    input  logic [ADDR_WD-1:0] line_sel,
    input  logic [ADDR_WD-1:0] lut_addr,
    input  logic               lut_we,
    input  logic [DLY_WD-1:0]  lut_din,
    input  logic [HALF_WD-1:0] half_per,
    input  logic [CYC_WD-1:0]  n_cycles,
    output logic               tx_p,
    output logic               tx_n,
    output logic               tx_busy,
    output logic               tx_done
);

    import tx_pkg::*;

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [DLY_WD-1:0]  dly_cnt;
    logic [DLY_WD-1:0]  dly_nxt;
    logic [HALF_WD-1:0] half_cnt;
    logic [HALF_WD-1:0] half_cnt_nxt;
    logic [CYC_WD:0]    half_idx;
    logic [CYC_WD:0]    half_idx_nxt;
    logic [HALF_WD-1:0] h_lat;
    logic [CYC_WD-1:0]  n_lat;
    logic [HALF_WD-1:0] h_last;
    logic [CYC_WD:0]    last_idx;
    logic [DLY_WD-1:0]  lut_rdata;
    logic               accept;
    logic               pulse_on;
    logic               dead;
    logic               p_nxt;
    logic               n_nxt;

    assign accept   = (state == ST_IDLE) && fire && tx_en;
    assign h_last   = h_lat - 1'b1;
    assign last_idx = {n_lat, 1'b0} - 1'b1;

    tx_dly_lut #(
        .ADDR_WD (ADDR_WD),
        .DLY_WD  (DLY_WD)
    ) u_lut (
        .clk   (clk),
        .we    (lut_we),
        .waddr (lut_addr),
        .wdata (lut_din),
        .re    (accept),
        .raddr (line_sel),
        .rdata (lut_rdata)
    );

    always_comb begin
        state_nxt    = state;
        dly_nxt      = dly_cnt;
        half_cnt_nxt = half_cnt;
        half_idx_nxt = half_idx;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dly_nxt      = lut_rdata;
                half_cnt_nxt = '0;
                half_idx_nxt = '0;
                if (lut_rdata != '0) begin
                    state_nxt = ST_DELAY;
                end else if (n_lat == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_PULSE;
                end
            end
            ST_DELAY: begin
                if (dly_cnt <= DLY_WD'(1)) begin
                    dly_nxt      = '0;
                    half_cnt_nxt = '0;
                    half_idx_nxt = '0;
                    state_nxt    = (n_lat == '0) ? ST_DONE : ST_PULSE;
                end else begin
                    dly_nxt = dly_cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (half_cnt == h_last) begin
                    half_cnt_nxt = '0;
                    if (half_idx == last_idx) begin
                        state_nxt = ST_DONE;
                    end else begin
                        half_idx_nxt = half_idx + 1'b1;
                    end
                end else begin
                    half_cnt_nxt = half_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Dropping the transmit window abandons everything, including a same-cycle fire.
        if (!tx_en) begin
            state_nxt    = ST_IDLE;
            dly_nxt      = '0;
            half_cnt_nxt = '0;
            half_idx_nxt = '0;
        end
    end

    // Even half indices drive tx_p, odd ones tx_n; outputs are derived from the
    // next state so the registered pins line up with the state they belong to.
    always_comb begin
        pulse_on = (state_nxt == ST_PULSE);
`ifdef TX_DEADTIME_EN
        dead = (half_cnt_nxt == '0) && (half_idx_nxt != '0);
`else
        dead = 1'b0;
`endif
        p_nxt = pulse_on && !dead && !half_idx_nxt[0];
        n_nxt = pulse_on && !dead && half_idx_nxt[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dly_cnt  <= '0;
            half_cnt <= '0;
            half_idx <= '0;
            h_lat    <= '0;
            n_lat    <= '0;
            tx_p     <= 1'b0;
            tx_n     <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dly_cnt  <= dly_nxt;
            half_cnt <= half_cnt_nxt;
            half_idx <= half_idx_nxt;
            if (accept) begin
                h_lat <= (half_per == '0) ? HALF_WD'(1) : half_per;
                n_lat <= n_cycles;
            end
            tx_p    <= p_nxt;
            tx_n    <= n_nxt;
            tx_busy <= (state_nxt != ST_IDLE);
            tx_done <= (state_nxt == ST_DONE);
        end
    end

endmodule
